spi_slave_core: RTL and testbench

Synthesizable SPI slave that forms the far end of the team's SPI master link: it receives the master's select, serial clock and MOSI lines and returns data on MISO. All pad inputs are oversampled and synchronized into a single system clock domain; there is no logic clocked by SCLK. A simple valid/ready host port supplies transmit words and delivers received words, so the block can serve as a DUT-side responder or as a reusable peripheral.

---
 rtl/spi_slave_core.sv | 111 +++++++++++
 tb/tb_spi_slave_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave with a valid/ready host port, all logic in the clk domain
// Ports: clk, rst (sync, active high); ss_n/sclk/mosi pad inputs; miso/miso_oe pad outputs;
//   cfg_cpol/cfg_cpha/cfg_lsb mode and bit order, latched on select; tx_data/tx_valid/tx_ready
//   transmit holding register; rx_data/rx_valid received word; busy, tx_underrun, frame_abort status.
module spi_slave_core #(
   parameter int CHAR_LEN    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ss_n,
   input  logic                sclk,
   input  logic                mosi,
   output logic                miso,
   output logic                miso_oe,
   input  logic                cfg_cpol,
   input  logic                cfg_cpha,
   input  logic                cfg_lsb,
   input  logic [CHAR_LEN-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [CHAR_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic                tx_underrun,
   output logic                frame_abort
);
   localparam int CW = $clog2(CHAR_LEN + 1);
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic ss_d, sclk_d, ss_s, sclk_s, mosi_s;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall, sample, shift, load, xfer;
   logic cpol, cpha, lsb, hold_full;
   logic [CHAR_LEN-1:0] tx_shift, rx_shift, hold_data;
   logic [CW-1:0] bit_cnt;
   always_comb begin
      ss_s      = ss_sync[SYNC_STAGES-1];
      sclk_s    = sclk_sync[SYNC_STAGES-1];
      mosi_s    = mosi_sync[SYNC_STAGES-1];
      ss_fall   = ss_d & ~ss_s;
      ss_rise   = ~ss_d & ss_s;
      sclk_rise = ~sclk_d & sclk_s;
      sclk_fall = sclk_d & ~sclk_s;
      sample    = state == ACTIVE && ((cpol ^ cpha) ? sclk_fall : sclk_rise);
      // a shift edge at bit_cnt 0 is either the cpha=1 lead edge (bit 0 already presented)
      // or the trailing edge of the previous back-to-back frame; neither may advance
      shift     = state == ACTIVE && bit_cnt != '0 && ((cpol ^ cpha) ? sclk_rise : sclk_fall);
      load      = (state == IDLE && ss_fall) || (state == DONE && !ss_s);
      tx_ready  = !hold_full;
      xfer      = tx_valid && tx_ready;
      busy      = state != IDLE;
      miso_oe   = busy;
      miso      = busy && (lsb ? tx_shift[0] : tx_shift[CHAR_LEN-1]);
      state_nx  = ss_rise ? IDLE :
                  (state == IDLE && ss_fall) ? ACTIVE :
                  (sample && bit_cnt == CW'(CHAR_LEN - 1)) ? DONE :
                  (state == DONE) ? (ss_s ? IDLE : ACTIVE) : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_d      <= ss_s;
         sclk_d    <= sclk_s;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {cpol, cpha, lsb} <= '0;
         hold_full   <= 1'b0;
         hold_data   <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         bit_cnt     <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         rx_valid    <= state == DONE;
         tx_underrun <= load && !hold_full;
         frame_abort <= state == ACTIVE && ss_rise && bit_cnt != '0 && bit_cnt < CW'(CHAR_LEN);
         hold_full   <= xfer || (hold_full && !load);
         if (xfer) hold_data <= tx_data;
         if (state == IDLE && ss_fall) {cpol, cpha, lsb} <= {cfg_cpol, cfg_cpha, cfg_lsb};
         if (state == DONE) rx_data <= rx_shift;
         if (load) begin
            tx_shift <= hold_full ? hold_data : '0;
            bit_cnt  <= '0;
         end else begin
            if (sample) begin
               rx_shift <= lsb ? {mosi_s, rx_shift[CHAR_LEN-1:1]} : {rx_shift[CHAR_LEN-2:0], mosi_s};
               if (bit_cnt < CW'(CHAR_LEN)) bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift) tx_shift <= lsb ? tx_shift >> 1 : tx_shift << 1;
         end
      end
   end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: randomized SPI master plus host model with a scoreboard on rx_valid
module tb_spi_slave_core;
   localparam int W = 32;
   localparam int H = 6;
   logic clk = 0, rst = 1, ss_n = 1, sclk = 0, mosi = 0;
   logic cfg_cpol = 0, cfg_cpha = 0, cfg_lsb = 0;
   logic [W-1:0] tx_data = '0;
   logic tx_valid = 0;
   logic miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
   logic [W-1:0] rx_data, got, last_rx = '0;
   logic [W-1:0] hold_q[$];
   logic [W-1:0] rx_exp[$];
   int checks = 0, fails = 0;
   int underrun_exp = 0, underrun_seen = 0, abort_exp = 0, abort_seen = 0;

   spi_slave_core #(.CHAR_LEN(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .tx_underrun(tx_underrun), .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_underrun) underrun_seen++;
      if (frame_abort) abort_seen++;
      if (rx_valid) begin
         if (rx_exp.size() == 0) check("rx_valid unexpected", rx_valid, 0);
         else begin
            last_rx = rx_exp.pop_front();
            check("rx_data", rx_data, last_rx);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, " miso"}, miso, 0);
      check({tag, " miso_oe"}, miso_oe, 0);
      check({tag, " tx_ready"}, tx_ready, 1);
      check({tag, " rx_data"}, rx_data, 0);
      check({tag, " rx_valid"}, rx_valid, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " tx_underrun"}, tx_underrun, 0);
      check({tag, " frame_abort"}, frame_abort, 0);
   endtask

   task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
      cfg_cpol = cpol;
      cfg_cpha = cpha;
      cfg_lsb = lsb;
      sclk = cpol;
      wait_clk(10);
   endtask

   task automatic host_write(input logic [W-1:0] w);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) check("tx_ready wait", tx_ready, 1);
      else begin
         tx_data = w;
         tx_valid = 1;
         hold_q.push_back(w);
         @(negedge clk);
         tx_valid = 0;
         check("tx_ready after write", tx_ready, 0);
      end
   endtask

   // One master frame; the expected MISO word is whatever the host queued, or zero on underrun
   task automatic frame(input logic [W-1:0] mo, input int nbits, input bit end_sel,
                        input bit first, output logic [W-1:0] rd);
      int idx;
      bit last;
      logic [W-1:0] exp;
      rd = '0;
      if (first) begin
         ss_n = 0;
         wait_clk(8);
      end
      if (hold_q.size() != 0) exp = hold_q.pop_front();
      else begin
         exp = '0;
         underrun_exp++;
      end
      if (nbits == W) rx_exp.push_back(mo);
      for (int i = 0; i < nbits; i++) begin
         idx = cfg_lsb ? i : W - 1 - i;
         last = (i == nbits - 1) && end_sel;
         if (!cfg_cpha) begin
            mosi = mo[idx];
            wait_clk(H);
            sclk = ~cfg_cpol;
            rd[idx] = miso;
            if (last) begin
               wait_clk(1);
               ss_n = 1;
            end
            wait_clk(H);
            sclk = cfg_cpol;
         end else begin
            wait_clk(H);
            sclk = ~cfg_cpol;
            mosi = mo[idx];
            wait_clk(H);
            sclk = cfg_cpol;
            rd[idx] = miso;
            if (last) begin
               wait_clk(1);
               ss_n = 1;
            end
         end
      end
      if (end_sel) wait_clk(2 * H);
      if (nbits == W) check("miso word", rd, exp);
   endtask

   task automatic check_counts(input string tag);
      check({tag, " underrun count"}, underrun_seen, underrun_exp);
      check({tag, " abort count"}, abort_seen, abort_exp);
      check({tag, " rx pending"}, rx_exp.size(), 0);
   endtask

   initial begin
      logic [W-1:0] pat[2];
      logic [2:0] m;
      pat[0] = 32'h8000_0001;
      pat[1] = 32'h0000_00FF;
      wait_clk(4);
      check_reset("reset");
      rst = 0;
      wait_clk(4);

      set_mode(0, 0, 0);
      host_write(32'hA5A5_0F0F);
      frame(32'h1234_5678, W, 1, 1, got);
      check("tx_ready after load", tx_ready, 1);
      check("busy after frame", busy, 0);
      check("miso_oe deselected", miso_oe, 0);
      check_counts("mode0");

      for (int c = 0; c < 8; c++) begin
         set_mode(c[0], c[1], c[2]);
         for (int p = 0; p < 2; p++) begin
            host_write(pat[p]);
            frame(pat[1-p], W, 1, 1, got);
         end
      end
      check_counts("modes");

      for (int c = 0; c < 2; c++) begin
         set_mode(c[0], c[0], 0);
         host_write(32'h1111_1111);
         fork
            begin
               frame($urandom, W, 0, 1, got);
               frame($urandom, W, 1, 0, got);
            end
            host_write(32'h2222_2222);
         join
         check_counts("back-to-back");
      end

      set_mode(1, 0, 1);
      check("tx_ready before underrun", tx_ready, 1);
      frame($urandom, W, 1, 1, got);
      check_counts("underrun");

      set_mode(0, 1, 0);
      host_write($urandom);
      frame($urandom, 13, 1, 1, got);
      abort_exp++;
      check_counts("abort");
      check("rx_data kept after abort", rx_data, last_rx);
      check("busy after abort", busy, 0);
      host_write($urandom);
      frame($urandom, W, 1, 1, got);
      check_counts("after abort");

      set_mode(0, 0, 0);
      host_write($urandom);
      frame($urandom, 20, 0, 1, got);
      rst = 1;
      ss_n = 1;
      @(negedge clk);
      check_reset("mid-frame reset");
      rst = 0;
      hold_q.delete();
      last_rx = '0;
      wait_clk(10);
      host_write($urandom);
      frame($urandom, W, 1, 1, got);
      check_counts("after reset");

      for (int k = 0; k < 12; k++) begin
         m = 3'($urandom_range(0, 7));
         set_mode(m[0], m[1], m[2]);
         if ($urandom_range(0, 3) != 0) host_write($urandom);
         frame($urandom, W, 1, 1, got);
      end
      check_counts("random");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
